ldst_branch_encoder: RTL and testbench

- Inverse of the datapath immediate extractor: packs a format selector, register fields and a 64-bit signed immediate into a 32-bit LEGv8 instruction word.
- Covers the same three formats the decoder recognises: D (LDUR/STUR), B, CB (CBZ).
- Checks that the immediate fits the target field. Out-of-range requests are dropped and flagged.
- Streams encoded words with a byte address to the instruction-memory loader used by test programs. Two-stage valid/ready pipeline, one word per cycle throughput.

---
 rtl/ldst_branch_encoder_if.sv | 27 ++
 rtl/ldst_branch_encoder.sv | 83 ++++++++
 tb/tb_ldst_branch_encoder.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ldst_branch_encoder_if.sv
// ldst_branch_encoder_if: request, output word and error-report signals of the LEGv8 encoder
interface ldst_branch_encoder_if #(
   parameter int CNT_W = 16
);
   logic in_valid;
   logic in_ready;
   logic [1:0] in_fmt;
   logic in_st;
   logic [4:0] in_rn;
   logic [4:0] in_rt;
   logic [63:0] in_imm;
   logic out_valid;
   logic out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_addr;
   logic err_valid;
   logic [1:0] err_code;
   logic [CNT_W-1:0] err_count;
   modport master (
      output in_valid, in_fmt, in_st, in_rn, in_rt, in_imm, out_ready,
      input in_ready, out_valid, out_instr, out_addr, err_valid, err_code, err_count
   );
   modport slave (
      input in_valid, in_fmt, in_st, in_rn, in_rt, in_imm, out_ready,
      output in_ready, out_valid, out_instr, out_addr, err_valid, err_code, err_count
   );
endinterface

// File: rtl/ldst_branch_encoder.sv
// ldst_branch_encoder: packs LEGv8 D/B/CB instructions and streams them with byte addresses
module ldst_branch_encoder #(
   parameter logic [63:0] BASE_ADDR = 64'h0,
   parameter int CNT_W = 16
) (
   input logic CLK,
   input logic Reset,
   ldst_branch_encoder_if.slave bus
);
   logic a_valid_q, a_valid_d, a_err_q, a_err_d;
   logic [1:0] a_code_q, a_code_d;
   logic [31:0] a_instr_q, a_instr_d;
   logic b_valid_q, b_valid_d;
   logic [31:0] b_instr_q, b_instr_d;
   logic [63:0] b_addr_q, b_addr_d;
   logic err_valid_q, err_valid_d;
   logic [1:0] err_code_q, err_code_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic b_free, accept, a_to_b, drop, fits, enc_err;
   logic [1:0] enc_code;
   logic [31:0] enc_instr;
   logic [10:0] d_opc;
   always_comb begin
      d_opc = bus.in_st ? 11'b11111000000 : 11'b11111000010;
      fits = bus.in_fmt == 2'b00 ? (&bus.in_imm[63:8] | ~|bus.in_imm[63:8]) :
             bus.in_fmt == 2'b01 ? (&bus.in_imm[63:25] | ~|bus.in_imm[63:25]) :
                                   (&bus.in_imm[63:18] | ~|bus.in_imm[63:18]);
      enc_err = bus.in_fmt == 2'b11 || !fits;
      enc_code = bus.in_fmt == 2'b11 ? 2'b10 : 2'b01;
      enc_instr = bus.in_fmt == 2'b00 ? {d_opc, bus.in_imm[8:0], 2'b00, bus.in_rn, bus.in_rt} :
                  bus.in_fmt == 2'b01 ? {6'b000101, bus.in_imm[25:0]} :
                                        {8'b10110100, bus.in_imm[18:0], bus.in_rt};
   end
   // An error entry always leaves A next cycle, so it never blocks a new capture
   always_comb begin
      b_free = !b_valid_q || bus.out_ready;
      a_to_b = a_valid_q && !a_err_q && b_free;
      drop = a_valid_q && a_err_q;
      bus.in_ready = !a_valid_q || a_err_q || b_free;
      accept = bus.in_valid && bus.in_ready;
      a_valid_d = accept || (a_valid_q && !a_err_q && !b_free);
      a_err_d = accept ? enc_err : a_err_q;
      a_code_d = accept ? enc_code : a_code_q;
      a_instr_d = accept ? enc_instr : a_instr_q;
      b_valid_d = a_to_b || (b_valid_q && !bus.out_ready);
      b_instr_d = a_to_b ? a_instr_q : b_instr_q;
      b_addr_d = (b_valid_q && bus.out_ready) ? b_addr_q + 64'd4 : b_addr_q;
      err_valid_d = drop;
      err_code_d = drop ? a_code_q : err_code_q;
      err_count_d = (drop && !(&err_count_q)) ? err_count_q + 1'b1 : err_count_q;
   end
   always_ff @(posedge CLK) begin
      if (Reset) begin
         a_valid_q <= 1'b0;
         a_err_q <= 1'b0;
         a_code_q <= 2'b00;
         a_instr_q <= 32'h0;
         b_valid_q <= 1'b0;
         b_instr_q <= 32'h0;
         b_addr_q <= BASE_ADDR;
         err_valid_q <= 1'b0;
         err_code_q <= 2'b00;
         err_count_q <= '0;
      end else begin
         a_valid_q <= a_valid_d;
         a_err_q <= a_err_d;
         a_code_q <= a_code_d;
         a_instr_q <= a_instr_d;
         b_valid_q <= b_valid_d;
         b_instr_q <= b_instr_d;
         b_addr_q <= b_addr_d;
         err_valid_q <= err_valid_d;
         err_code_q <= err_code_d;
         err_count_q <= err_count_d;
      end
   end
   assign bus.out_valid = b_valid_q;
   assign bus.out_instr = b_instr_q;
   assign bus.out_addr = b_addr_q;
   assign bus.err_valid = err_valid_q;
   assign bus.err_code = err_code_q;
   assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_ldst_branch_encoder.sv
// tb_ldst_branch_encoder: scoreboard bench for the LEGv8 encoder against a range/arithmetic model
module tb_ldst_branch_encoder;
   localparam logic [63:0] BASE = 64'h0;
   logic clk = 1'b0;
   logic Reset = 1'b1;
   ldst_branch_encoder_if #(.CNT_W(16)) bus ();
   ldst_branch_encoder #(.BASE_ADDR(BASE), .CNT_W(16)) dut (.CLK(clk), .Reset(Reset), .bus(bus));
   always #5 clk = ~clk;
   int errors = 0, checks = 0;
   logic [31:0] wq[$];
   logic [1:0] eq[$];
   logic [63:0] exp_addr = BASE;
   int exp_cnt = 0;
   bit rand_rdy = 0, fixed_rdy = 1;
   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // Reference: field must hold imm as a signed N-bit value; words built by shift/mask arithmetic
   function automatic void model(input logic [1:0] f, input logic st, input logic [4:0] rn, input logic [4:0] rt,
                                 input logic [63:0] imm, output bit ok, output logic [31:0] w, output logic [1:0] c);
      longint s, lim;
      int n;
      s = imm;
      n = f == 2'd0 ? 9 : f == 2'd1 ? 26 : 19;
      lim = longint'(1) <<< (n - 1);
      ok = f != 2'd3 && s >= -lim && s < lim;
      c = f == 2'd3 ? 2'd2 : 2'd1;
      if (f == 2'd0)
         w = 32'(((st ? 64'h7C0 : 64'h7C2) << 21) | ((s & 64'h1FF) << 12) | (longint'(rn) << 5) | longint'(rt));
      else if (f == 2'd1)
         w = 32'((64'h5 << 26) | (s & 64'h3FFFFFF));
      else
         w = 32'((64'hB4 << 24) | ((s & 64'h7FFFF) << 5) | longint'(rt));
   endfunction
   task automatic push_cur();
      bit ok;
      logic [31:0] w;
      logic [1:0] c;
      model(bus.in_fmt, bus.in_st, bus.in_rn, bus.in_rt, bus.in_imm, ok, w, c);
      if (ok) wq.push_back(w);
      else eq.push_back(c);
   endtask
   task automatic set_req(input logic [1:0] f, input logic st, input logic [4:0] rn, input logic [4:0] rt, input logic [63:0] imm);
      bus.in_fmt = f;
      bus.in_st = st;
      bus.in_rn = rn;
      bus.in_rt = rt;
      bus.in_imm = imm;
   endtask
   // Called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send(input logic [1:0] f, input logic st, input logic [4:0] rn, input logic [4:0] rt,
                       input logic [63:0] imm, output int waits);
      set_req(f, st, rn, rt, imm);
      bus.in_valid = 1'b1;
      waits = 0;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            push_cur();
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            return;
         end
         waits++;
      end
      chk(0, "in_ready_timeout", 0, 1);
      bus.in_valid = 1'b0;
   endtask
   task automatic wait_drain();
      for (int t = 0; t < 1000; t++) begin
         @(negedge clk);
         if (wq.size() == 0 && eq.size() == 0) begin
            @(posedge clk);
            #1;
            return;
         end
      end
      chk(0, "drain_timeout", 64'(wq.size() + eq.size()), 0);
   endtask
   initial forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : fixed_rdy;
   end
   // Monitor: pops expected words/errors whenever the DUT presents them
   initial begin
      bit held = 0;
      logic [31:0] h_instr;
      logic [63:0] h_addr;
      forever begin
         @(negedge clk);
         if (Reset) held = 0;
         else begin
            if (bus.err_valid) begin
               if (eq.size() == 0) chk(0, "err_unexpected", 64'(bus.err_code), 0);
               else chk(bus.err_code == eq.pop_front(), "err_code", 64'(bus.err_code), 64'(1));
               if (exp_cnt < 65535) exp_cnt++;
               chk(bus.err_count == 16'(exp_cnt), "err_count", 64'(bus.err_count), 64'(exp_cnt));
            end
            if (bus.out_valid) begin
               if (held) begin
                  chk(bus.out_instr == h_instr, "hold_instr", 64'(bus.out_instr), 64'(h_instr));
                  chk(bus.out_addr == h_addr, "hold_addr", bus.out_addr, h_addr);
               end
               if (bus.out_ready) begin
                  if (wq.size() == 0) chk(0, "word_unexpected", 64'(bus.out_instr), 0);
                  else begin
                     logic [31:0] e;
                     e = wq.pop_front();
                     chk(bus.out_instr == e, "out_instr", 64'(bus.out_instr), 64'(e));
                  end
                  chk(bus.out_addr == exp_addr, "out_addr", bus.out_addr, exp_addr);
                  exp_addr += 64'd4;
                  held = 0;
               end else begin
                  held = 1;
                  h_instr = bus.out_instr;
                  h_addr = bus.out_addr;
               end
            end else held = 0;
         end
      end
   end
   initial begin
      int w, acc;
      logic [63:0] r;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      set_req(2'd0, 1'b0, 5'd0, 5'd0, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      Reset = 1'b0;
      @(negedge clk);
      chk(bus.out_valid == 1'b0, "rst_out_valid", 64'(bus.out_valid), 0);
      chk(bus.err_valid == 1'b0, "rst_err_valid", 64'(bus.err_valid), 0);
      chk(bus.err_code == 2'b00, "rst_err_code", 64'(bus.err_code), 0);
      chk(bus.err_count == 16'd0, "rst_err_count", 64'(bus.err_count), 0);
      chk(bus.out_instr == 32'h0, "rst_out_instr", 64'(bus.out_instr), 0);
      chk(bus.out_addr == BASE, "rst_out_addr", bus.out_addr, BASE);
      chk(bus.in_ready == 1'b1, "rst_in_ready", 64'(bus.in_ready), 1);
      @(posedge clk);
      #1;
      // LDUR X2,[X1,#8] and its two-stage latency
      send(2'd0, 1'b0, 5'd1, 5'd2, 64'd8, w);
      @(negedge clk);
      chk(bus.out_valid == 1'b0, "lat_edge1", 64'(bus.out_valid), 0);
      @(negedge clk);
      chk(bus.out_valid == 1'b1, "lat_edge2", 64'(bus.out_valid), 1);
      chk(bus.out_instr == 32'hF8408022, "ldur_word", 64'(bus.out_instr), 64'hF8408022);
      @(posedge clk);
      #1;
      wait_drain();
      send(2'd1, 1'b0, 5'd0, 5'd0, -64'sd1, w);
      chk(w == 0, "b2b_ready_b", 64'(w), 0);
      send(2'd2, 1'b0, 5'd0, 5'd3, -64'sd2, w);
      chk(w == 0, "b2b_ready_cb", 64'(w), 0);
      chk(wq.size() == 2 && wq[0] == 32'h17FFFFFF && wq[1] == 32'hB4FFFFC3, "model_words", 64'(wq.size()), 2);
      wait_drain();
      // Out-of-range D offsets just past both ends of the 9-bit field
      send(2'd0, 1'b1, 5'd4, 5'd5, 64'd256, w);
      @(negedge clk);
      chk(bus.err_valid == 1'b0, "err_lat1", 64'(bus.err_valid), 0);
      @(negedge clk);
      chk(bus.err_valid == 1'b1 && bus.out_valid == 1'b0, "err_pulse", 64'({bus.err_valid, bus.out_valid}), 64'b10);
      @(negedge clk);
      chk(bus.err_valid == 1'b0, "err_one_cycle", 64'(bus.err_valid), 0);
      @(posedge clk);
      #1;
      send(2'd0, 1'b0, 5'd4, 5'd5, -64'sd257, w);
      send(2'd0, 1'b1, 5'd6, 5'd7, 64'd255, w);
      send(2'd0, 1'b0, 5'd6, 5'd7, -64'sd256, w);
      send(2'd3, 1'b0, 5'd1, 5'd1, 64'd0, w);
      send(2'd1, 1'b0, 5'd0, 5'd0, 64'h1FFFFFF, w);
      send(2'd1, 1'b0, 5'd0, 5'd0, 64'h2000000, w);
      send(2'd2, 1'b0, 5'd0, 5'd9, -64'sd262144, w);
      send(2'd2, 1'b0, 5'd0, 5'd9, -64'sd262145, w);
      wait_drain();
      // Backpressure: only two requests may be buffered
      fixed_rdy = 0;
      @(posedge clk);
      #1;
      acc = 0;
      set_req(2'd0, 1'($urandom), 5'($urandom), 5'($urandom), 64'($signed(9'($urandom))));
      bus.in_valid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (bus.in_ready) begin
            push_cur();
            acc++;
         end
         @(posedge clk);
         #1;
         set_req(2'd0, 1'($urandom), 5'($urandom), 5'($urandom), 64'($signed(9'($urandom))));
      end
      chk(acc == 2, "bp_accepted", 64'(acc), 2);
      @(negedge clk);
      chk(bus.in_ready == 1'b0, "bp_in_ready", 64'(bus.in_ready), 0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      fixed_rdy = 1;
      wait_drain();
      // Reset with two entries buffered
      fixed_rdy = 0;
      @(posedge clk);
      #1;
      send(2'd0, 1'b0, 5'd1, 5'd1, 64'd1, w);
      send(2'd1, 1'b0, 5'd0, 5'd0, 64'd2, w);
      Reset = 1'b1;
      wq.delete();
      eq.delete();
      exp_addr = BASE;
      exp_cnt = 0;
      @(posedge clk);
      #1;
      Reset = 1'b0;
      fixed_rdy = 1;
      @(negedge clk);
      chk(bus.out_valid == 1'b0, "mid_rst_out_valid", 64'(bus.out_valid), 0);
      chk(bus.in_ready == 1'b1, "mid_rst_in_ready", 64'(bus.in_ready), 1);
      chk(bus.err_count == 16'd0, "mid_rst_err_count", 64'(bus.err_count), 0);
      chk(bus.err_valid == 1'b0, "mid_rst_err_valid", 64'(bus.err_valid), 0);
      @(posedge clk);
      #1;
      send(2'd2, 1'b0, 5'd0, 5'd12, 64'd100, w);
      wait_drain();
      // Randomized traffic with random backpressure
      rand_rdy = 1;
      for (int i = 0; i < 300; i++) begin
         int k;
         k = $urandom_range(0, 9);
         r = {$urandom, $urandom};
         r = $signed(r) >>> $urandom_range(30, 63);
         send(k < 3 ? 2'd0 : k < 6 ? 2'd1 : k < 9 ? 2'd2 : 2'd3, 1'($urandom), 5'($urandom), 5'($urandom), r, w);
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      rand_rdy = 0;
      fixed_rdy = 1;
      wait_drain();
      chk(wq.size() == 0 && eq.size() == 0, "final_empty", 64'(wq.size() + eq.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
